// File: rtl/flip_inv_pkg.sv
// Shared types, frame geometry and address helpers for the flip/invert frame sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package flip_inv_pkg;

  // Sequencer phases: waiting for start, filling memory, streaming memory out
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } stateT;

  // Default frame geometry and memory address width
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int ADDR_W  = 24;

  // Raster-order linear address of pixel (x, y) in a frame w pixels wide
  function automatic int unsigned lin_addr(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned w);
    return y * w + x;
  endfunction

  // Reflect coordinate c about the centre of [0, last] when en is set
  function automatic int unsigned mirror(input int unsigned c,
                                         input int unsigned last,
                                         input logic        en);
    return en ? (last - c) : c;
  endfunction

endpackage

// File: rtl/flip_inv_ctrl_addr_gen.sv
// Raster x/y counters with optional mirroring, producing the linear memory address.
// Latency: address is combinational from the counters; counters step on the clock after adv.
// Backpressure: counters hold whenever adv is low; clr takes priority over adv.
module flip_addr_gen #(
  parameter int WIDTH  = flip_inv_pkg::FRAME_W,
  parameter int HEIGHT = flip_inv_pkg::FRAME_H,
  parameter int ADDR_W = flip_inv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic              flipH,
  input  logic              flipV,
  output logic              atEnd,
  output logic [ADDR_W-1:0] addr
);
  import flip_inv_pkg::*;

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;

  // Raster counters: x runs fastest, both wrap to zero after the last pixel of the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : (y + YW'(1));
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Source coordinate mapping and linear address; the caller forces flips low while loading
  always_comb begin
    sx    = XW'(mirror(32'(x), unsigned'(WIDTH - 1), flipH));
    sy    = YW'(mirror(32'(y), unsigned'(HEIGHT - 1), flipV));
    addr  = ADDR_W'(lin_addr(32'(sx), 32'(sy), unsigned'(WIDTH)));
    atEnd = (x == X_LAST) && (y == Y_LAST);
  end

endmodule

// File: rtl/flip_inv_ctrl.sv
// Frame sequencer: loads a raster pixel stream into the frame memory, then streams it back mirrored/inverted.
// Latency: writes are combinational on the input handshake; first output is valid one cycle after entering DRAIN.
// Backpressure: in_ready high throughout LOAD; single-slot output register holds while out_valid && !out_ready.
module flip_inv_ctrl #(
  parameter int WIDTH  = flip_inv_pkg::FRAME_W,
  parameter int HEIGHT = flip_inv_pkg::FRAME_H,
  parameter int ADDR_W = flip_inv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flip_h,
  input  logic              flip_v,
  input  logic              invert,
  input  logic              in_valid,
  input  logic              in_pixel,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data_in,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic              mem_data_out,
  output logic              out_valid,
  output logic              out_pixel,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);
  import flip_inv_pkg::*;

  stateT             state;
  stateT             stateNext;
  logic              flipHLat;
  logic              flipVLat;
  logic              invLat;
  logic              genClr;
  logic              genAdv;
  logic              genAtEnd;
  logic [ADDR_W-1:0] genAddr;
  logic              readEn;
  logic              lastHs;

  // Shared coordinate generator; mirroring only applies when reading the frame back
  flip_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) uAddrGen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (genClr),
    .adv   (genAdv),
    .flipH (flipHLat && (state == DRAIN)),
    .flipV (flipVLat && (state == DRAIN)),
    .atEnd (genAtEnd),
    .addr  (genAddr)
  );

  // Phase register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next phase, memory port and counter control; out_last gates further reads once the final pixel is held
  always_comb begin
    stateNext   = state;
    in_ready    = 1'b0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_data_in = 1'b0;
    genClr      = 1'b0;
    genAdv      = 1'b0;
    busy        = 1'b0;
    readEn      = 1'b0;
    lastHs      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = LOAD;
          genClr    = 1'b1;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        mem_addr = genAddr;
        if (in_valid) begin
          mem_wr      = 1'b1;
          mem_data_in = in_pixel;
          genAdv      = 1'b1;
          if (genAtEnd) begin
            stateNext = DRAIN;
            genClr    = 1'b1;
          end
        end
      end
      DRAIN: begin
        busy     = 1'b1;
        mem_addr = genAddr;
        readEn   = !out_last && (!out_valid || out_ready);
        mem_rd   = readEn;
        genAdv   = readEn;
        lastHs   = out_valid && out_ready && out_last;
        if (lastHs) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Frame mode is captured once per frame so mid-frame input changes are harmless
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flipHLat <= 1'b0;
      flipVLat <= 1'b0;
      invLat   <= 1'b0;
    end else if ((state == IDLE) && start) begin
      flipHLat <= flip_h;
      flipVLat <= flip_v;
      invLat   <= invert;
    end
  end

  // Single-slot output register: refill on a read, drain on an accept without refill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_last  <= 1'b0;
    end else if (readEn) begin
      out_valid <= 1'b1;
      out_pixel <= mem_data_out ^ invLat;
      out_last  <= genAtEnd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // End-of-frame pulse, one cycle after the final output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= lastHs;
    end
  end

endmodule
